// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with input FIFO, parity generation and 1/2 stop bits
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active high
//   baud_tick    1-clk strobe, one per bit period; the frame FSM and txd only move on it
//   s_valid      input word valid
//   s_ready      FIFO can accept a word (= !full)
//   s_data       word to transmit, LSB sent first
//   parity_mode  00 none, 01 even, 10 odd, 11 none; sampled when a word is popped
//   two_stop     0: one stop bit, 1: two stop bits; sampled when a word is popped
//   txd          registered serial output, idle high
//   busy         high whenever the frame FSM is not idle
//   tx_done      1-clk pulse after the tick that ends a frame's last stop bit
//   fifo_count   words currently buffered
module uart_tx_framer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             baud_tick,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_W-1:0]                s_data,
    input  logic [1:0]                       parity_mode,
    input  logic                             two_stop,
    output logic                             txd,
    output logic                             busy,
    output logic                             tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;

    // FIFO storage and pointers
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Frame datapath
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                two_stop_q, two_stop_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                txd_q, txd_d;
    logic                tx_done_q, tx_done_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                last_stop;
    logic [DATA_W-1:0]   head;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        push       = s_valid && !fifo_full;
        head       = mem_q[rd_ptr_q];

        // The tick that ends the final stop bit; stop_cnt counts 0 or 0..1.
        last_stop  = (state_q == S_STOP) && (stop_cnt_q == two_stop_q);

        // Pop decisions look only at count_q, so a word pushed this cycle
        // cannot be popped until the next one.
        pop        = baud_tick && !fifo_empty && ((state_q == S_IDLE) || last_stop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (last_stop) begin
                        state_d = fifo_empty ? S_IDLE : S_START;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath
    // ------------------------------------------------------------------
    always_comb begin
        txd_d      = txd_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;
        tx_done_d  = 1'b0;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                end
                S_START: begin
                    txd_d     = shreg_q[0];
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    if (bit_cnt_q != LAST_BIT) begin
                        // Bit 1 of the current register is the next bit on the wire.
                        txd_d     = shreg_q[1];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else if (par_en_q) begin
                        txd_d = par_bit_q;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
                S_PARITY: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (last_stop) begin
                        tx_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    txd_d = 1'b1;
                end
            endcase
        end

        // Loading a new word overrides the idle/stop level with the start bit.
        // Frame options are captured here so later input changes only affect
        // the next frame.
        if (pop) begin
            shreg_d    = head;
            par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d  = (^head) ^ (parity_mode == 2'b10);
            two_stop_d = two_stop;
            txd_d      = 1'b0;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        s_ready    = !fifo_full;
        txd        = txd_q;
        tx_done    = tx_done_q;
        fifo_count = count_q;
    end

    // ------------------------------------------------------------------
    // Datapath and FIFO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer (DATA_W=8 and DATA_W=7 instances)
module tb_uart_tx_framer;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_tick = 1'b0;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        s_valid8 = 1'b0;
    logic [7:0]  s_data8 = '0;
    logic        s_valid7 = 1'b0;
    logic [6:0]  s_data7 = '0;
    logic [1:0]  s_ready_a;
    logic [1:0]  txd_a;
    logic [1:0]  busy_a;
    logic [1:0]  done_a;
    logic [2:0]  cnt8;
    logic [2:0]  cnt7;

    frame_t      exp0[$];
    frame_t      exp1[$];
    int          checks = 0;
    int          passed = 0;
    int          done_cnt [2];
    int          busy_ticks [2];

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_W(8), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .s_valid(s_valid8), .s_ready(s_ready_a[0]), .s_data(s_data8),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .txd(txd_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]), .fifo_count(cnt8)
    );

    uart_tx_framer #(.DATA_W(7), .FIFO_DEPTH(4)) u_dut7 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .s_valid(s_valid7), .s_ready(s_ready_a[1]), .s_data(s_data7),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .txd(txd_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]), .fifo_count(cnt7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference frame: start bit, data LSB first, optional parity, stop bits.
    function automatic frame_t make_frame(input logic [15:0] word, input int dw,
                                          input logic [1:0] pm, input logic ts);
        frame_t f;
        int     n;
        logic   p;
        f.bits = '0;
        n = 0;
        p = 1'b0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < dw; i++) begin
            f.bits[n] = word[i];
            p = p ^ word[i];
            n++;
        end
        if (pm == 2'b01) begin f.bits[n] = p;  n++; end
        if (pm == 2'b10) begin f.bits[n] = ~p; n++; end
        for (int i = 0; i < (ts ? 2 : 1); i++) begin f.bits[n] = 1'b1; n++; end
        f.len = n;
        return f;
    endfunction

    // Monitor: collects txd after every tick edge while busy, closes a frame on tx_done.
    initial begin : monitor
        logic [15:0] cur [2];
        int          cur_len [2];
        logic        tk;
        frame_t      e;
        for (int k = 0; k < 2; k++) begin cur[k] = '0; cur_len[k] = 0; end
        forever begin
            @(posedge clk);
            tk = baud_tick;
            #1;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    cur[k] = '0;
                    cur_len[k] = 0;
                end else begin
                    if (done_a[k] === 1'b1) done_cnt[k]++;
                    if (tk) begin
                        if (busy_a[k] === 1'b1) busy_ticks[k]++;
                        if (done_a[k] === 1'b1) begin
                            if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
                                checks++;
                                $display("FAIL unexpected_frame dut%0d: got frame of %0d bits, expected none", k, cur_len[k]);
                            end else begin
                                e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                                check($sformatf("frame_len_dut%0d", k), cur_len[k], e.len);
                                check($sformatf("frame_bits_dut%0d", k), {16'h0, cur[k]}, {16'h0, e.bits});
                            end
                            cur[k] = '0;
                            cur_len[k] = 0;
                        end
                        if (busy_a[k] === 1'b1) begin
                            if (cur_len[k] < 16) cur[k][cur_len[k]] = txd_a[k];
                            cur_len[k]++;
                        end
                    end
                end
            end
        end
    end

    task automatic bit_period();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push8(input logic [7:0] w);
        check("s_ready_push8", s_ready_a[0], 1);
        s_valid8 = 1'b1;
        s_data8 = w;
        exp0.push_back(make_frame({8'h0, w}, 8, parity_mode, two_stop));
        @(negedge clk);
        s_valid8 = 1'b0;
    endtask

    task automatic push7(input logic [6:0] w);
        check("s_ready_push7", s_ready_a[1], 1);
        s_valid7 = 1'b1;
        s_data7 = w;
        exp1.push_back(make_frame({9'h0, w}, 7, parity_mode, two_stop));
        @(negedge clk);
        s_valid7 = 1'b0;
    endtask

    task automatic drain(input int max_periods);
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < max_periods) begin
            bit_period();
            n++;
        end
        if (exp0.size() != 0 || exp1.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d/%0d frames pending after %0d periods, expected 0/0",
                     exp0.size(), exp1.size(), max_periods);
        end
        bit_period();
        bit_period();
    endtask

    initial begin : stimulus
        int n;
        int acc;
        logic [7:0] w8;
        logic [6:0] w7;
        done_cnt[0] = 0; done_cnt[1] = 0;
        busy_ticks[0] = 0; busy_ticks[1] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 2'b11);
        check("rst_busy", busy_a, 2'b00);
        check("rst_tx_done", done_a, 2'b00);
        check("rst_fifo_count", {cnt7, cnt8}, 6'd0);
        check("rst_s_ready", s_ready_a, 2'b11);
        rst = 1'b0;
        @(negedge clk);

        // 8N1, 0x55
        done_cnt[0] = 0;
        busy_ticks[0] = 0;
        push8(8'h55);
        drain(40);
        check("t1_done_pulses", done_cnt[0], 1);
        check("t1_busy_ticks", busy_ticks[0], 10);
        check("t1_idle_txd", txd_a[0], 1);

        // DATA_W=7, 0x41 with even then odd parity
        parity_mode = 2'b01;
        push7(7'h41);
        drain(40);
        parity_mode = 2'b10;
        push7(7'h41);
        drain(40);

        // Three back-to-back 8N2 frames
        parity_mode = 2'b00;
        two_stop = 1'b1;
        for (int i = 0; i < 3; i++) push8(8'($urandom));
        check("t3_count_start", cnt8, 3);
        done_cnt[0] = 0;
        n = 0;
        while (done_cnt[0] < 3 && n < 60) begin
            bit_period();
            n++;
        end
        check("t3_ticks_to_third_done", n, 34);
        check("t3_count_end", cnt8, 0);
        bit_period();
        check("t3_done_pulses", done_cnt[0], 3);
        check("t3_queue_empty", exp0.size(), 0);
        two_stop = 1'b0;

        // Fill with no ticks, then same-cycle push and pop
        acc = 0;
        s_valid8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data8 = 8'($urandom);
            if (s_ready_a[0]) begin
                acc++;
                exp0.push_back(make_frame({8'h0, s_data8}, 8, parity_mode, two_stop));
            end
            @(negedge clk);
        end
        s_valid8 = 1'b0;
        check("t4_accepts", acc, 4);
        check("t4_s_ready_full", s_ready_a[0], 0);
        check("t4_count_full", cnt8, 4);
        bit_period();
        check("t4_count_after_pop", cnt8, 3);
        repeat (9) bit_period();
        check("t4_s_ready_before_pp", s_ready_a[0], 1);
        baud_tick = 1'b1;
        s_valid8 = 1'b1;
        s_data8 = 8'($urandom);
        exp0.push_back(make_frame({8'h0, s_data8}, 8, parity_mode, two_stop));
        @(negedge clk);
        baud_tick = 1'b0;
        s_valid8 = 1'b0;
        check("t4_count_push_pop", cnt8, 3);
        check("t4_busy_gapless", busy_a[0], 1);
        repeat (3) @(negedge clk);
        drain(100);

        // Reset in the middle of a DATA bit
        push8(8'hA5);
        bit_period();
        push8(8'h3C);
        bit_period();
        bit_period();
        check("t5_pre_reset_txd", txd_a[0], 0);
        check("t5_pre_reset_count", cnt8, 1);
        #2;
        rst = 1'b1;
        exp0.delete();
        #1;
        check("t5_rst_txd", txd_a[0], 1);
        check("t5_rst_busy", busy_a[0], 0);
        check("t5_rst_count", cnt8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push8(8'h96);
        drain(40);

        // Parity change mid-frame applies to the next frame only
        parity_mode = 2'b00;
        push8(8'($urandom));
        bit_period();
        bit_period();
        parity_mode = 2'b01;
        push8(8'h07);
        drain(60);

        // Randomized batches on both instances
        for (int b = 0; b < 10; b++) begin
            parity_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                w8 = 8'($urandom);
                w7 = 7'($urandom);
                push8(w8);
                push7(w7);
            end
            drain(80);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
